// File: rtl/multiply_add_stg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiply_add_stg_pkg : state encodings and widths shared by the mul/div pair
// Revision: 1.0
// ---------------------------------------------------------------------------
package multiply_add_stg_pkg;

    localparam int L_divn = 8;
    localparam int L_divr = 4;

    localparam logic [1:0] S_idle = 2'd0;
    localparam logic [1:0] S_run  = 2'd1;
    localparam logic [1:0] S_done = 2'd2;

    typedef struct packed {
        logic load_acc;
        logic load_ops;
        logic step;
    } dp_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multiply_add_stg_shift_add_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_add_datapath : accumulator plus shifting multiplicand/multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
module shift_add_datapath
    import multiply_add_stg_pkg::*;
#(
    parameter int L_mcnd = L_divn,
    parameter int L_mplr = L_divr,
    parameter int L_prod = L_mcnd + L_mplr
) (
    input  logic              clock,
    input  logic              reset,
    input  dp_ctrl_t          ctrl,
    input  logic [L_mcnd-1:0] word1,
    input  logic [L_mplr-1:0] word2,
    input  logic [L_mplr-1:0] addend,
    output logic [L_prod-1:0] acc,
    output logic              last_step
);

    logic [L_prod-1:0] acc_q,  acc_d;
    logic [L_prod-1:0] mcnd_q, mcnd_d;
    logic [L_mplr-1:0] mplr_q, mplr_d;

    always_comb begin
        acc_d  = acc_q;
        mcnd_d = mcnd_q;
        mplr_d = mplr_q;
        if (ctrl.step) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcnd_q;
            end
            mcnd_d = mcnd_q << 1;
            mplr_d = mplr_q >> 1;
        end else begin
            if (ctrl.load_acc) begin
                acc_d = L_prod'(addend);
            end
            if (ctrl.load_ops) begin
                mcnd_d = L_prod'(word1);
                mplr_d = word2;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            mcnd_q <= '0;
            mplr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            mcnd_q <= mcnd_d;
            mplr_q <= mplr_d;
        end
    end

    assign acc = acc_q;
    // The step now in progress consumes the last set multiplier bit.
    assign last_step = ((mplr_q >> 1) == '0);

endmodule
`default_nettype wire

// File: rtl/multiply_add_stg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiply_add_stg : sequential shift-add product = word1 * word2 + addend
// Revision: 1.0
// ---------------------------------------------------------------------------
module multiply_add_stg
    import multiply_add_stg_pkg::*;
#(
    parameter int L_mcnd  = L_divn,
    parameter int L_mplr  = L_divr,
    parameter int L_prod  = L_mcnd + L_mplr,
    parameter int L_state = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Start,
    input  logic [L_mcnd-1:0] word1,
    input  logic [L_mplr-1:0] word2,
    input  logic [L_mplr-1:0] addend,
    output logic [L_prod-1:0] product,
    output logic              Ready
);

    logic [L_state-1:0] state_q, state_d;
    dp_ctrl_t           ctrl;
    logic               last_step;

    always_comb begin
        state_d       = state_q;
        ctrl.load_acc = 1'b0;
        ctrl.load_ops = 1'b0;
        ctrl.step     = 1'b0;
        case (state_q)
            S_idle, S_done: begin
                if (Start) begin
                    ctrl.load_acc = 1'b1;
                    // A zero operand leaves just the addend, so skip the run.
                    if ((word1 != '0) && (word2 != '0)) begin
                        ctrl.load_ops = 1'b1;
                        state_d       = S_run;
                    end else begin
                        state_d       = S_done;
                    end
                end
            end
            S_run: begin
                ctrl.step = 1'b1;
                if (last_step) begin
                    state_d = S_done;
                end
            end
            default: state_d = S_idle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_idle;
        end else begin
            state_q <= state_d;
        end
    end

    shift_add_datapath #(
        .L_mcnd (L_mcnd),
        .L_mplr (L_mplr),
        .L_prod (L_prod)
    ) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .ctrl      (ctrl),
        .word1     (word1),
        .word2     (word2),
        .addend    (addend),
        .acc       (product),
        .last_step (last_step)
    );

    assign Ready = ((state_q == S_idle) && !reset) || (state_q == S_done);

endmodule
`default_nettype wire

// File: tb/tb_multiply_add_stg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multiply_add_stg : vector table, random and round-trip checks
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multiply_add_stg;

    logic        clock = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  word1;
    logic [3:0]  word2;
    logic [3:0]  addend;
    logic [11:0] product;
    logic        Ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int w1;
        int w2;
        int ad;
        int prod;
        int lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    multiply_add_stg dut (
        .clock   (clock),
        .reset   (reset),
        .Start   (Start),
        .word1   (word1),
        .word2   (word2),
        .addend  (addend),
        .product (product),
        .Ready   (Ready)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: cycles to Ready = 1 for a zero operand, else bit length of w2 plus 1.
    function automatic int ref_lat(input int w1, input int w2);
        if (w1 == 0 || w2 == 0) return 1;
        return $clog2(w2 + 1) + 1;
    endfunction

    task automatic run_op(input int w1, input int w2, input int ad, output int lat);
        @(negedge clock);
        word1  = 8'(w1);
        word2  = 4'(w2);
        addend = 4'(ad);
        Start  = 1'b1;
        @(posedge clock);
        #1;
        Start = 1'b0;
        lat   = 1;
        while (!Ready && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!Ready && lat < 20);
    endtask

    initial begin
        int lat;
        int w1, w2, ad;
        int held;

        reset  = 1'b1;
        Start  = 1'b0;
        word1  = '0;
        word2  = '0;
        addend = '0;

        vecs.push_back('{200, 13,  7, 2607, 5});
        vecs.push_back('{ 77,  0,  5,    5, 1});
        vecs.push_back('{  0,  9,  9,    9, 1});
        vecs.push_back('{255, 15, 15, 3840, 5});
        vecs.push_back('{ 10,  3,  1,   31, 3});
        vecs.push_back('{  1,  1,  0,    1, 2});
        vecs.push_back('{255,  8,  0, 2040, 5});
        vecs.push_back('{  3,  2, 15,   21, 3});

        repeat (2) @(negedge clock);
        check("reset_ready", int'(Ready), 0);
        check("reset_product", int'(product), 0);
        reset = 1'b0;
        #1;
        check("post_reset_ready", int'(Ready), 1);
        check("post_reset_product", int'(product), 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].w1, vecs[i].w2, vecs[i].ad, lat);
            check($sformatf("vec%0d_product", i), int'(product), vecs[i].prod);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        held = int'(product);
        repeat (3) @(posedge clock);
        #1;
        check("done_hold_product", int'(product), held);
        check("done_hold_ready", int'(Ready), 1);

        for (int n = 0; n < 300; n++) begin
            w1 = int'($urandom_range(0, 255));
            w2 = int'($urandom_range(0, 15));
            ad = int'($urandom_range(0, 15));
            run_op(w1, w2, ad, lat);
            check($sformatf("rand %0d*%0d+%0d", w1, w2, ad), int'(product), w1 * w2 + ad);
            check($sformatf("rand_lat w2=%0d", w2), lat, ref_lat(w1, w2));
        end

        for (int a = 1; a <= 255; a++) begin
            for (int b = 1; b <= 15; b++) begin
                run_op(a / b, b, a % b, lat);
                check($sformatf("roundtrip %0d/%0d", a, b), int'(product), a);
            end
        end

        // Reset asserted during the second S_run cycle of 255*15.
        @(negedge clock);
        word1  = 8'd255;
        word2  = 4'd15;
        addend = 4'd0;
        Start  = 1'b1;
        @(posedge clock);
        #1;
        Start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_reset_product", int'(product), 0);
        check("midrun_reset_ready", int'(Ready), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("after_abort_ready", int'(Ready), 1);
        check("after_abort_product", int'(product), 0);
        run_op(10, 3, 1, lat);
        check("after_abort_op", int'(product), 31);
        check("after_abort_lat", lat, 3);

        // Start pulse and operand changes during S_run must not disturb the run.
        @(negedge clock);
        word1  = 8'd200;
        word2  = 4'd13;
        addend = 4'd7;
        Start  = 1'b1;
        @(posedge clock);
        #1;
        Start  = 1'b0;
        word1  = 8'd1;
        word2  = 4'd1;
        addend = 4'd0;
        lat    = 1;
        @(posedge clock);
        #1;
        lat++;
        Start = 1'b1;
        @(posedge clock);
        #1;
        lat++;
        Start = 1'b0;
        while (!Ready && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("pulse_ignored_product", int'(product), 2607);
        check("pulse_ignored_lat", lat, 5);

        // Start held high: each completion relaunches with the operands then present.
        @(negedge clock);
        word1  = 8'd7;
        word2  = 4'd5;
        addend = 4'd3;
        Start  = 1'b1;
        wait_done(lat);
        check("b2b_a_product", int'(product), 38);
        check("b2b_a_lat", lat, 4);
        word1  = 8'd9;
        word2  = 4'd0;
        addend = 4'd2;
        wait_done(lat);
        check("b2b_b_product", int'(product), 2);
        check("b2b_b_lat", lat, 1);
        word1  = 8'd6;
        word2  = 4'd6;
        addend = 4'd1;
        wait_done(lat);
        check("b2b_c_product", int'(product), 37);
        check("b2b_c_lat", lat, 4);
        @(negedge clock);
        Start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
